id_ex_stage: RTL and testbench

- ID/EX pipeline register that directly feeds the ALU in the execute stage.
- Latches decoded operands and control from ID and applies EX/MEM and MEM/WB forwarding to the ALU operands.
- Detects load-use hazards: stalls ID and inserts a bubble.
- Supports flush on taken branch.

---
 rtl/id_ex_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register feeding the execute-stage ALU. Latches decoded
//   operands and controls, resolves EX/MEM and MEM/WB forwarding on the ALU
//   operands, detects load-use hazards (stall ID + bubble) and kills the
//   instruction entering EX on a taken-branch flush.
//
// Optional feature macro: ID_EX_STALL_COUNT_EN
//   When defined, adds a saturating 32-bit stall_count output that counts
//   cycles with stall_id=1 and flush=0 (cleared by reset only).
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : taken branch, bubble into EX
//   id_*                  : decoded instruction fields from ID
//   exm_*                 : EX/MEM producer (reg_write, rd, result)
//   wb_*                  : MEM/WB producer (reg_write, rd, data)
//   ex_valid, ex_rd, ex_* : registered EX-stage controls
//   data1, data2          : forwarded ALU operands
//   ex_store_data         : forwarded rt value for stores
//   control_signals, sh_am: registered ALU control and shift amount
//   stall_id              : combinational load-use stall for PC and IF/ID
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [4:0]        id_sh_am,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exm_reg_write,
    input  logic [REG_W-1:0]  exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [3:0]        control_signals,
    output logic [4:0]        sh_am,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              stall_id
`ifdef ID_EX_STALL_COUNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned SH_W   = 5;

    logic              valid_q,      valid_d;
    logic [REG_W-1:0]  rs_q,         rs_d;
    logic [REG_W-1:0]  rt_q,         rt_d;
    logic [REG_W-1:0]  rd_q,         rd_d;
    logic [DATA_W-1:0] rs_data_q,    rs_data_d;
    logic [DATA_W-1:0] rt_data_q,    rt_data_d;
    logic [DATA_W-1:0] imm_q,        imm_d;
    logic              alu_src_q,    alu_src_d;
    logic [CTRL_W-1:0] alu_ctrl_q,   alu_ctrl_d;
    logic [SH_W-1:0]   sh_am_q,      sh_am_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    logic              wb_hit_id_rs, wb_hit_id_rt;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // Load in EX whose destination is read by the instruction in ID
    assign stall_id = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                      ((rd_q == id_rs) || (rd_q == id_rt));

    // Same-cycle register-file write-through for the ID read ports
    assign wb_hit_id_rs = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs);
    assign wb_hit_id_rt = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt);

    // Next-state: bubble clears controls and holds data, else capture ID
    always_comb begin
        valid_d      = valid_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        alu_src_d    = alu_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        sh_am_d      = sh_am_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (flush || stall_id) begin
            valid_d      = 1'b0;
            rd_d         = '0;
            alu_ctrl_d   = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else begin
            valid_d      = id_valid;
            rs_d         = id_rs;
            rt_d         = id_rt;
            rd_d         = id_rd;
            rs_data_d    = wb_hit_id_rs ? wb_data : id_rs_data;
            rt_data_d    = wb_hit_id_rt ? wb_data : id_rt_data;
            imm_d        = id_imm;
            alu_src_d    = id_alu_src;
            alu_ctrl_d   = id_alu_ctrl;
            sh_am_d      = id_sh_am;
            reg_write_d  = id_reg_write;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            mem_to_reg_d = id_mem_to_reg;
        end
    end

    // Pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            sh_am_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            sh_am_q      <= sh_am_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // Operand forwarding: EX/MEM has priority over MEM/WB, r0 never forwarded
    always_comb begin
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs_q)) begin
            fwd_a = exm_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q)) begin
            fwd_a = wb_data;
        end else begin
            fwd_a = rs_data_q;
        end
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rt_q)) begin
            fwd_b = exm_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q)) begin
            fwd_b = wb_data;
        end else begin
            fwd_b = rt_data_q;
        end
    end

    assign data1           = fwd_a;
    assign data2           = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data   = fwd_b;
    assign ex_valid        = valid_q;
    assign ex_rd           = rd_q;
    assign control_signals = alu_ctrl_q;
    assign sh_am           = sh_am_q;
    assign ex_reg_write    = reg_write_q;
    assign ex_mem_read     = mem_read_q;
    assign ex_mem_write    = mem_write_q;
    assign ex_mem_to_reg   = mem_to_reg_q;

`ifdef ID_EX_STALL_COUNT_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of genuine load-use stalls (flush cycles excluded)
    always_comb begin
        cnt_d = cnt_q;
        if (stall_id && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_alu_src;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_sh_am;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        ex_valid;
    logic [31:0] data1, data2, ex_store_data;
    logic [3:0]  control_signals;
    logic [4:0]  sh_am;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        stall_id;
`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_sh_am(id_sh_am),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .data1(data1), .data2(data2),
        .control_signals(control_signals), .sh_am(sh_am),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .stall_id(stall_id)
`ifdef ID_EX_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    // ---------------- behavioural model of the EX-stage contents ----------------
    logic        m_init = 1'b0;
    logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
    logic [4:0]  m_rs, m_rt, m_rd, m_sh;
    logic [3:0]  m_ctrl;
    logic [31:0] m_rsv, m_rtv, m_imm, m_cnt;

    // Value a register read sees once MEM/WB has written this cycle
    function automatic logic [31:0] wt(input logic [4:0] idx, input logic [31:0] v);
        return (wb_reg_write && wb_rd != 5'd0 && wb_rd == idx) ? wb_data : v;
    endfunction

    // Newest in-flight value of a register: EX/MEM first, then MEM/WB
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
        if (exm_reg_write && exm_rd != 5'd0 && exm_rd == idx) return exm_result;
        return wt(idx, v);
    endfunction

    function automatic logic exp_stall();
        return m_valid && m_mr && m_rd != 5'd0 && id_valid &&
               (m_rd == id_rs || m_rd == id_rt);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init <= 1'b1;
            m_valid <= 0; m_src <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0;
            m_rs <= 0; m_rt <= 0; m_rd <= 0; m_sh <= 0; m_ctrl <= 0;
            m_rsv <= 0; m_rtv <= 0; m_imm <= 0; m_cnt <= 0;
        end else begin
            if (exp_stall() && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
            if (flush || exp_stall()) begin
                m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0;
                m_ctrl <= 0; m_rd <= 0;
            end else begin
                m_valid <= id_valid; m_rs <= id_rs; m_rt <= id_rt; m_rd <= id_rd;
                m_rsv <= wt(id_rs, id_rs_data); m_rtv <= wt(id_rt, id_rt_data);
                m_imm <= id_imm; m_src <= id_alu_src; m_ctrl <= id_alu_ctrl;
                m_sh <= id_sh_am; m_rw <= id_reg_write; m_mr <= id_mem_read;
                m_mw <= id_mem_write; m_m2r <= id_mem_to_reg;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (!m_init) return;
        check("m_ex_valid", 32'(ex_valid), 32'(m_valid));
        check("m_data1", data1, fwd(m_rs, m_rsv));
        check("m_data2", data2, m_src ? m_imm : fwd(m_rt, m_rtv));
        check("m_store", ex_store_data, fwd(m_rt, m_rtv));
        check("m_ctrl", 32'(control_signals), 32'(m_ctrl));
        check("m_sh_am", 32'(sh_am), 32'(m_sh));
        check("m_ex_rd", 32'(ex_rd), 32'(m_rd));
        check("m_ctl_bits", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
              {28'd0, m_rw, m_mr, m_mw, m_m2r});
        check("m_stall", 32'(stall_id), 32'(exp_stall()));
`ifdef ID_EX_STALL_COUNT_EN
        check("m_stall_count", stall_count, m_cnt);
`endif
    endtask

    // Compare at the falling edge, then advance to just after the next rising edge
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_src = 0; id_alu_ctrl = 0; id_sh_am = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic src, input logic [3:0] ctrl,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src = src;
        id_alu_ctrl = ctrl; id_sh_am = 5'd0;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic rand_in();
        flush = ($urandom_range(0, 7) == 0); id_valid = 1'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3)); id_alu_src = 1'($urandom);
        id_alu_ctrl = 4'($urandom); id_sh_am = 5'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
        id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
        exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
        wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
    endtask

    initial begin
        // Reset with random inputs
        idle(); rand_in(); reset = 1;
        @(posedge clk); #1;
        rand_in(); #1;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_data1", data1, 32'd0);
        check("rst_data2", data2, 32'd0);
        check("rst_store", ex_store_data, 32'd0);
        check("rst_stall", 32'(stall_id), 32'd0);
        step();
        rand_in(); #1;
        check("rst_ctrl", 32'(control_signals), 32'd0);
        check("rst_rw", 32'(ex_reg_write), 32'd0);
        step();

        // add r3,r1,r2
        reset = 0; idle();
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0010, 1, 0, 0, 0);
        step(); idle(); #1;
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_data1", data1, 32'd5);
        check("add_data2", data2, 32'd7);
        check("add_ctrl", 32'(control_signals), 32'd2);
        check("add_rd", 32'(ex_rd), 32'd3);

        // EX/MEM beats MEM/WB on rs=r3
        set_id(5'd3, 5'd0, 5'd7, 32'd5, 32'd0, 32'd0, 1'b0, 4'b0110, 1, 0, 0, 0);
        step(); idle();
        exm_reg_write = 1; exm_rd = 5'd3; exm_result = 32'd12;
        wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'd99; #1;
        check("fwd_exm_pri", data1, 32'd12);
        exm_reg_write = 0; #1;
        check("fwd_wb", data1, 32'd99);
        wb_reg_write = 0; #1;
        check("fwd_none", data1, 32'd5);

        // Load-use: lw r4 then add r5,r4,r2
        set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8, 1'b1, 4'b0010, 1, 1, 0, 1);
        step(); idle();
        set_id(5'd4, 5'd2, 5'd5, 32'hAAAA, 32'd3, 32'd0, 1'b0, 4'b0010, 1, 0, 0, 0); #1;
        check("lu_stall", 32'(stall_id), 32'd1);
        check("lw_data2_imm", data2, 32'd8);
        step(); #1;
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_ctrl", 32'(control_signals), 32'd0);
        check("lu_bubble_rd", 32'(ex_rd), 32'd0);
        check("lu_stall_clear", 32'(stall_id), 32'd0);
        wb_reg_write = 1; wb_rd = 5'd4; wb_data = 32'h1234;
        step(); idle(); #1;
        check("lu_cap_valid", 32'(ex_valid), 32'd1);
        check("lu_cap_data1", data1, 32'h1234);
        check("lu_cap_data2", data2, 32'd3);
        check("lu_cap_rd", 32'(ex_rd), 32'd5);
`ifdef ID_EX_STALL_COUNT_EN
        check("cnt_after_lu", stall_count, 32'd1);
`endif

        // Flush together with a load-use stall
        set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8, 1'b1, 4'b0010, 1, 1, 0, 1);
        step(); idle();
        set_id(5'd4, 5'd2, 5'd5, 32'hAAAA, 32'd3, 32'd0, 1'b0, 4'b0010, 1, 0, 0, 0);
        flush = 1; #1;
        check("fl_stall_seen", 32'(stall_id), 32'd1);
        step(); idle(); #1;
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_rw", 32'(ex_reg_write), 32'd0);
        check("fl_mr", 32'(ex_mem_read), 32'd0);
`ifdef ID_EX_STALL_COUNT_EN
        check("cnt_after_flush", stall_count, 32'd1);
`endif

        // Register 0 guard
        set_id(5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010, 1, 0, 0, 0);
        step(); idle();
        exm_reg_write = 1; exm_rd = 5'd0; exm_result = 32'hDEAD; #1;
        check("r0_data1", data1, 32'd0);
        check("r0_data2", data2, 32'd0);
        exm_reg_write = 0;
        set_id(5'd1, 5'd0, 5'd0, 32'h200, 32'd0, 32'd4, 1'b1, 4'b0010, 1, 1, 0, 1);
        step(); idle();
        set_id(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010, 1, 0, 0, 0); #1;
        check("r0_lw_mr", 32'(ex_mem_read), 32'd1);
        check("r0_no_stall", 32'(stall_id), 32'd0);
        step(); idle();

        // ID write-through on rt
        set_id(5'd1, 5'd6, 5'd10, 32'd1, 32'h11, 32'd0, 1'b0, 4'b0000, 1, 0, 0, 0);
        wb_reg_write = 1; wb_rd = 5'd6; wb_data = 32'h55;
        step(); idle(); #1;
        check("wt_data2", data2, 32'h55);
        check("wt_store", ex_store_data, 32'h55);

        // Mixed traffic on a small register set, checked against the model
        for (int i = 0; i < 300; i++) begin
            rand_in();
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 0; idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
